// File: rtl/tlul_socket_m1_rr_pkg.sv
// Shared TL-UL types and socket helpers.
// Contents: TL-UL field widths, A/D opcode enums, host-to-device and device-to-host
// channel structs, socket limits, and source-tag insert/strip helpers.
package tlul_socket_m1_rr_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;

  // Socket limits
  localparam int unsigned SocketMaxHosts       = 4;
  localparam int unsigned SocketMaxOutstanding = 7;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

  // Host index goes into the low tag_w bits; host source bits shift up.
  function automatic logic [TL_AIW-1:0] src_tag_insert(input logic [TL_AIW-1:0] src,
                                                       input logic [TL_AIW-1:0] idx,
                                                       input int unsigned       tag_w);
    return (src << tag_w) | idx;
  endfunction

  function automatic logic [TL_AIW-1:0] src_tag_strip(input logic [TL_AIW-1:0] src,
                                                      input int unsigned       tag_w);
    return src >> tag_w;
  endfunction

endpackage

// File: rtl/tlul_socket_m1_rr_if.sv
// Bus bundle for the N:1 socket.
// Signals: tl_h_i (host A requests + d_ready), tl_h_o (host D responses + a_ready),
// tl_d_o (device request), tl_d_i (device response).
// Modports: master = hosts/device environment, slave = the socket.
interface tlul_socket_m1_rr_if #(
  parameter int unsigned NumHosts = 3
) ();
  import tlul_socket_m1_rr_pkg::*;

  tl_h2d_t tl_h_i [NumHosts];
  tl_d2h_t tl_h_o [NumHosts];
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;

  modport master (
    output tl_h_i,
    output tl_d_i,
    input  tl_h_o,
    input  tl_d_o
  );

  modport slave (
    input  tl_h_i,
    input  tl_d_i,
    output tl_h_o,
    output tl_d_o
  );
endinterface

// File: rtl/tlul_socket_m1_rr_arb.sv
// Round-robin arbiter with lock-while-stalled (rr_arb_tree_lock role).
// Ports: clk_i/rst_i (async active-high), req_i request vector, ready_i downstream ready,
// grant_o one-hot grant, idx_o granted index, valid_o granted request is valid.
// The pointer rotates to winner+1 on handshake; a stalled grant is held until accepted.
module tlul_socket_m1_rr_arb #(
  parameter  int unsigned NumReq = 3,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              ready_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [IdxW-1:0] r_ptr, r_lock_idx;
  logic            r_lock;
  logic            w_found;
  logic [IdxW-1:0] w_idx;

  always_comb begin
    int unsigned c;
    w_found = 1'b0;
    w_idx   = r_ptr;
    c       = 0;
    for (int k = 0; k < NumReq; k++) begin
      c = (int'(r_ptr) + k) % NumReq;
      if (!w_found && req_i[c]) begin
        w_found = 1'b1;
        w_idx   = IdxW'(c);
      end
    end
    // A stalled transfer keeps its grant so the A fields stay stable.
    if (r_lock) begin
      w_found = 1'b1;
      w_idx   = r_lock_idx;
    end
  end

  assign idx_o   = w_idx;
  assign grant_o = w_found ? (NumReq'(1) << w_idx) : '0;
  assign valid_o = w_found & req_i[w_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (valid_o) begin
      if (ready_i) begin
        r_lock <= 1'b0;
        r_ptr  <= (w_idx == IdxW'(NumReq - 1)) ? '0 : w_idx + IdxW'(1);
      end else begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_idx;
      end
    end
  end

endmodule

// File: rtl/tlul_socket_m1_rr.sv
// N:1 TL-UL socket: NumHosts hosts share one device port, combinational in both directions.
// Ports: clk_i, rst_i (async active-high), tl_bus (slave modport: host/device channels),
// route_err_o (pulse while a D beat carries an unroutable source and is dropped).
// Host index is tagged into the low a_source bits; D beats are demuxed on that tag.
// Per-host outstanding counters gate eligibility and validate returning D beats.
module tlul_socket_m1_rr
  import tlul_socket_m1_rr_pkg::*;
#(
  parameter int unsigned NumHosts       = 3,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tlul_socket_m1_rr_if.slave   tl_bus,
  output logic                 route_err_o
);

  localparam int unsigned StIdW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0]     r_outst [NumHosts];
  logic [NumHosts-1:0] w_elig, w_grant, w_a_hs, w_d_hs;
  logic [StIdW-1:0]    w_gidx, w_didx;
  logic                w_a_valid, w_d_ok, w_d_host_ready;

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      w_elig[i] = tl_bus.tl_h_i[i].a_valid && (r_outst[i] < CntW'(MaxOutstanding));
    end
  end

  tlul_socket_m1_rr_arb #(
    .NumReq (NumHosts)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (w_elig),
    .ready_i (tl_bus.tl_d_i.a_ready),
    .grant_o (w_grant),
    .idx_o   (w_gidx),
    .valid_o (w_a_valid)
  );

  // D routing: a beat is deliverable only to an existing host with something in flight.
  assign w_didx = tl_bus.tl_d_i.d_source[StIdW-1:0];

  always_comb begin
    w_d_ok         = 1'b0;
    w_d_host_ready = 1'b0;
    for (int i = 0; i < NumHosts; i++) begin
      if (w_didx == StIdW'(i)) begin
        w_d_ok         = (r_outst[i] != '0);
        w_d_host_ready = tl_bus.tl_h_i[i].d_ready;
      end
    end
  end

  always_comb begin
    tl_bus.tl_d_o          = tl_bus.tl_h_i[w_gidx];
    tl_bus.tl_d_o.a_valid  = w_a_valid;
    tl_bus.tl_d_o.a_source = src_tag_insert(tl_bus.tl_h_i[w_gidx].a_source,
                                            TL_AIW'(w_gidx), StIdW);
    // Unroutable beats are swallowed so the device never stalls on them.
    tl_bus.tl_d_o.d_ready  = w_d_ok ? w_d_host_ready : 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      tl_bus.tl_h_o[i]          = tl_bus.tl_d_i;
      tl_bus.tl_h_o[i].d_source = src_tag_strip(tl_bus.tl_d_i.d_source, StIdW);
      tl_bus.tl_h_o[i].d_valid  = tl_bus.tl_d_i.d_valid & w_d_ok & (w_didx == StIdW'(i));
      tl_bus.tl_h_o[i].a_ready  = tl_bus.tl_d_i.a_ready & w_grant[i];
      w_a_hs[i] = w_a_valid & tl_bus.tl_d_i.a_ready & w_grant[i];
      w_d_hs[i] = tl_bus.tl_d_i.d_valid & w_d_ok & (w_didx == StIdW'(i)) &
                  tl_bus.tl_h_i[i].d_ready;
    end
  end

  assign route_err_o = tl_bus.tl_d_i.d_valid & ~w_d_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumHosts; i++) r_outst[i] <= '0;
    end else begin
      for (int i = 0; i < NumHosts; i++) begin
        if (w_a_hs[i] && !w_d_hs[i]) begin
          r_outst[i] <= r_outst[i] + CntW'(1);
        end else if (!w_a_hs[i] && w_d_hs[i]) begin
          r_outst[i] <= r_outst[i] - CntW'(1);
        end
      end
    end
  end

  // Hosts must leave the tag bits of a_source clear.
  for (genvar gi = 0; gi < NumHosts; gi++) begin : g_src_chk
    a_src_upper_zero: assert property (@(posedge clk_i) disable iff (rst_i)
      tl_bus.tl_h_i[gi].a_valid |-> (tl_bus.tl_h_i[gi].a_source[TL_AIW-1 -: StIdW] == '0));
  end

endmodule

// File: tb/tb_tlul_socket_m1_rr.sv
// Self-checking bench for tlul_socket_m1_rr: directed scenarios followed by random traffic,
// compared every cycle against a count/queue-based reference model.
module tb_tlul_socket_m1_rr;
  import tlul_socket_m1_rr_pkg::*;

  localparam int NH   = 3;
  localparam int MAXO = 2;
  localparam int TW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic route_err;

  always #5 clk = ~clk;

  tlul_socket_m1_rr_if #(.NumHosts(NH)) tl_bus ();

  tlul_socket_m1_rr #(
    .NumHosts       (NH),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_bus      (tl_bus),
    .route_err_o (route_err)
  );

  // Stimulus state
  bit          h_av   [NH];
  logic [7:0]  h_src  [NH];
  logic [31:0] h_addr [NH];
  bit          h_dr   [NH];
  bit          dev_ar, d_v;
  logic [7:0]  d_src;
  logic [31:0] d_data;

  // Reference model: pointer, pending stalled host, per-host in-flight counts
  int m_ptr, m_lock;
  int m_out [NH];
  int tagq [$];
  int e_win, e_didx;
  bit e_av, e_dok;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NH-1:0] ar_vec();
    logic [NH-1:0] v;
    for (int i = 0; i < NH; i++) v[i] = tl_bus.tl_h_o[i].a_ready;
    return v;
  endfunction

  function automatic logic [NH-1:0] dv_vec();
    logic [NH-1:0] v;
    for (int i = 0; i < NH; i++) v[i] = tl_bus.tl_h_o[i].d_valid;
    return v;
  endfunction

  task automatic idle();
    for (int i = 0; i < NH; i++) begin
      h_av[i]   = 1'b0;
      h_src[i]  = 8'h00;
      h_addr[i] = 32'h0;
      h_dr[i]   = 1'b1;
    end
    dev_ar = 1'b1;
    d_v    = 1'b0;
    d_src  = 8'h00;
    d_data = 32'h0;
  endtask

  task automatic apply();
    for (int i = 0; i < NH; i++) begin
      tl_bus.tl_h_i[i]           = '0;
      tl_bus.tl_h_i[i].a_valid   = h_av[i];
      tl_bus.tl_h_i[i].a_opcode  = Get;
      tl_bus.tl_h_i[i].a_size    = 2'd2;
      tl_bus.tl_h_i[i].a_source  = h_src[i];
      tl_bus.tl_h_i[i].a_address = h_addr[i];
      tl_bus.tl_h_i[i].a_mask    = 4'hf;
      tl_bus.tl_h_i[i].d_ready   = h_dr[i];
    end
    tl_bus.tl_d_i          = '0;
    tl_bus.tl_d_i.a_ready  = dev_ar;
    tl_bus.tl_d_i.d_valid  = d_v;
    tl_bus.tl_d_i.d_opcode = AccessAckData;
    tl_bus.tl_d_i.d_source = d_src;
    tl_bus.tl_d_i.d_data   = d_data;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lock = -1;
    for (int i = 0; i < NH; i++) m_out[i] = 0;
    tagq.delete();
  endtask

  // Drive inputs, then compare every observable against the model.
  task automatic pre();
    bit            elig [NH];
    logic [NH-1:0] e_ar, e_dv;
    int            c;
    apply();
    #1;
    e_win = -1;
    for (int i = 0; i < NH; i++) elig[i] = h_av[i] && (m_out[i] < MAXO);
    if (m_lock >= 0) e_win = m_lock;
    else begin
      for (int k = 0; k < NH; k++) begin
        c = (m_ptr + k) % NH;
        if (e_win < 0 && elig[c]) e_win = c;
      end
    end
    e_av   = (e_win >= 0) && h_av[e_win];
    e_didx = int'(d_src[1:0]);
    e_dok  = (e_didx < NH) ? (m_out[e_didx] > 0) : 1'b0;
    e_ar   = '0;
    if (e_win >= 0 && dev_ar) e_ar[e_win] = 1'b1;
    e_dv = '0;
    if (d_v && e_dok) e_dv[e_didx] = 1'b1;

    chk("a_valid", tl_bus.tl_d_o.a_valid, e_av);
    if (e_av) begin
      chk("a_source", tl_bus.tl_d_o.a_source, ((h_src[e_win] << TW) | e_win) & 8'hff);
      chk("a_address", tl_bus.tl_d_o.a_address, h_addr[e_win]);
    end
    chk("a_ready_vec", ar_vec(), e_ar);
    chk("d_valid_vec", dv_vec(), e_dv);
    if (d_v && e_dok) begin
      chk("host_d_source", tl_bus.tl_h_o[e_didx].d_source, d_src >> TW);
      chk("host_d_data", tl_bus.tl_h_o[e_didx].d_data, d_data);
    end
    chk("dev_d_ready", tl_bus.tl_d_o.d_ready, e_dok ? h_dr[e_didx] : 1'b1);
    chk("route_err", route_err, d_v && !e_dok);
  endtask

  // Clock edge, then advance the model by the handshakes that edge completed.
  task automatic post();
    @(posedge clk);
    if (e_av && dev_ar) begin
      m_out[e_win]++;
      m_ptr  = (e_win + 1) % NH;
      m_lock = -1;
      tagq.push_back(((h_src[e_win] << TW) | e_win) & 255);
    end else if (e_av) begin
      m_lock = e_win;
    end
    if (d_v && e_dok && h_dr[e_didx]) begin
      m_out[e_didx]--;
      for (int j = 0; j < tagq.size(); j++) begin
        if (tagq[j] % 4 == e_didx) begin
          tagq.delete(j);
          break;
        end
      end
    end
    #1;
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      if (tagq.size() > 0) begin
        idle();
        d_v   = 1'b1;
        d_src = 8'(tagq[0]);
        cycle();
      end
    end
    chk("drain_empty", tagq.size(), 0);
  endtask

  // Asynchronous reset asserted between edges; outputs checked before any edge.
  task automatic do_reset();
    rst = 1'b1;
    idle();
    apply();
    #1;
    chk("rst_a_valid", tl_bus.tl_d_o.a_valid, 1'b0);
    chk("rst_a_ready", ar_vec(), '0);
    chk("rst_d_valid", dv_vec(), '0);
    chk("rst_route_err", route_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int          r;
    logic [7:0]  late_tag;
    model_reset();
    idle();
    apply();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single request from host 1 and its response
    idle();
    h_av[1] = 1'b1; h_src[1] = 8'h05; h_addr[1] = 32'h10;
    pre();
    chk("tp1_a_source", tl_bus.tl_d_o.a_source, 8'h15);
    chk("tp1_grant", ar_vec(), 3'b010);
    post();
    idle();
    d_v = 1'b1; d_src = 8'h15; d_data = 32'hcafe_0001;
    pre();
    chk("tp1_d_source", tl_bus.tl_h_o[1].d_source, 8'h05);
    chk("tp1_d_valid", dv_vec(), 3'b010);
    post();

    // Rotation with all hosts requesting and immediate responses
    do_reset();
    for (int n = 0; n < 6; n++) begin
      idle();
      for (int i = 0; i < NH; i++) begin
        h_av[i]   = 1'b1;
        h_src[i]  = 8'(n);
        h_addr[i] = 32'h100 * (i + 1) + 32'(n);
      end
      if (tagq.size() > 0) begin
        d_v = 1'b1; d_src = 8'(tagq[0]);
      end
      pre();
      chk("tp2_grant", ar_vec(), 3'b001 << (n % 3));
      post();
    end
    drain();

    // Lock on host 2 while the device stalls
    for (int n = 0; n < 5; n++) begin
      idle();
      h_av[2] = 1'b1; h_src[2] = 8'h2a; h_addr[2] = 32'h2000;
      h_av[0] = (n > 0);  h_src[0] = 8'h11; h_addr[0] = 32'h0100;
      dev_ar  = (n >= 3);
      pre();
      if (n < 4) begin
        chk("tp3_lock_tag", tl_bus.tl_d_o.a_source[1:0], 2'd2);
        chk("tp3_lock_addr", tl_bus.tl_d_o.a_address, 32'h2000);
      end else begin
        chk("tp3_after_lock", ar_vec(), 3'b001);
      end
      post();
    end
    drain();

    // Outstanding limit on host 0
    for (int n = 0; n < 7; n++) begin
      idle();
      h_av[0] = 1'b1; h_src[0] = 8'(n); h_addr[0] = 32'h3000 + 32'(n);
      h_av[1] = (n == 2); h_addr[1] = 32'h3100;
      if (n == 3 || n == 4) begin
        d_v = 1'b1; d_src = 8'(tagq[0]);
      end
      pre();
      case (n)
        2: chk("tp4_h0_blocked", ar_vec(), 3'b010);
        3: chk("tp4_h0_still_full", ar_vec(), 3'b000);
        4: chk("tp4_h0_reenabled", ar_vec(), 3'b001);
        5: chk("tp4_h0_refill", ar_vec(), 3'b001);
        6: chk("tp4_h0_full_again", ar_vec(), 3'b000);
        default: ;
      endcase
      post();
    end
    drain();

    // Out-of-range and unowned responses are dropped
    idle();
    for (int i = 0; i < NH; i++) h_dr[i] = 1'b0;
    d_v = 1'b1; d_src = 8'h03;
    pre();
    chk("tp5_idx3_err", route_err, 1'b1);
    chk("tp5_idx3_dready", tl_bus.tl_d_o.d_ready, 1'b1);
    post();
    d_src = 8'h01;
    pre();
    chk("tp5_unowned_err", route_err, 1'b1);
    chk("tp5_unowned_dvalid", dv_vec(), 3'b000);
    post();
    idle();
    pre();
    chk("tp5_err_pulse", route_err, 1'b0);
    post();

    // Reset in the middle of a lock with traffic in flight
    for (int n = 0; n < 4; n++) begin
      idle();
      h_av[0] = (n == 0); h_src[0] = 8'h07; h_addr[0] = 32'h4000;
      h_av[1] = (n == 1 || n == 2); h_src[1] = 8'(n); h_addr[1] = 32'h4100;
      h_av[2] = (n == 3); h_src[2] = 8'h09; h_addr[2] = 32'h4200;
      dev_ar  = (n < 3);
      cycle();
    end
    chk("tp6_outst_h0", m_out[0], 1);
    late_tag = 8'(tagq[0]);
    do_reset();
    idle();
    h_av[1] = 1'b1; h_addr[1] = 32'h5100;
    h_av[2] = 1'b1; h_addr[2] = 32'h5200;
    pre();
    chk("tp6_post_reset_grant", ar_vec(), 3'b010);
    post();
    idle();
    d_v = 1'b1; d_src = late_tag;
    pre();
    chk("tp6_late_d_err", route_err, 1'b1);
    post();
    drain();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NH; i++) begin
        if (m_lock != i) begin
          h_av[i]   = 1'($urandom);
          h_src[i]  = {2'b00, 6'($urandom)};
          h_addr[i] = $urandom;
        end
        h_dr[i] = ($urandom_range(3) != 0);
      end
      dev_ar = ($urandom_range(2) != 0);
      d_v    = 1'b0;
      d_data = $urandom;
      r      = int'($urandom_range(7));
      if (tagq.size() > 0 && r < 5) begin
        d_v   = 1'b1;
        d_src = 8'(tagq[$urandom_range(tagq.size() - 1)]);
      end else if (r == 5) begin
        d_v   = 1'b1;
        d_src = {6'($urandom), 2'b11};
      end else if (r == 6) begin
        d_v   = 1'b1;
        d_src = 8'($urandom);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
